// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads, bypass,
// background clear engine and per-register pending scoreboard.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   we/waddr/wdata        write port (ignored while clr_busy)
//   raddr_a/b, rdata_a/b  read ports, data valid one cycle after address
//   pend_set/pend_addr    mark a register as awaiting writeback
//   pend_a/b              pending bit of raddr_a/b (pre-edge state)
//   clr_req               start full-file clear
//   clr_busy, clr_done    clear in progress / one-cycle completion pulse
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  localparam logic [ADDR_W-1:0] IDX_FIRST =
    ZR ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic busy;
  logic wr_en;
  logic sweep_en;
  logic clr_start;

  assign busy  = (state_q == S_SWEEP);
  // Writes to a hardwired entry 0 vanish here, so
  // bypass and scoreboard never see them either.
  assign wr_en = we && !busy &&
                 !(ZR && (waddr == '0));

  // Clear engine
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_start = 1'b0;
    sweep_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d   = S_SWEEP;
          idx_d     = IDX_FIRST;
          clr_start = 1'b1;
        end
      end
      S_SWEEP: begin
        sweep_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scoreboard: a new producer (set) beats a
  // retiring one (write) on the same entry.
  always_comb begin
    pend_d = pend_q;
    if (clr_start) begin
      pend_d = '0;
    end else begin
      if (wr_en) begin
        pend_d[waddr] = 1'b0;
      end
      if (pend_set && !busy) begin
        pend_d[pend_addr] = 1'b1;
      end
    end
    if (ZR) begin
      pend_d[0] = 1'b0;
    end
  end

  // Read ports
  always_comb begin
    rdata_a_d = mem_q[raddr_a];
    if (ZR && (raddr_a == '0)) begin
      rdata_a_d = '0;
    end else if (BP && wr_en &&
                 (waddr == raddr_a)) begin
      rdata_a_d = wdata;
    end
  end

  always_comb begin
    rdata_b_d = mem_q[raddr_b];
    if (ZR && (raddr_b == '0)) begin
      rdata_b_d = '0;
    end else if (BP && wr_en &&
                 (waddr == raddr_b)) begin
      rdata_b_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pend_q    <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Sweep and port writes are mutually exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (sweep_en) begin
        mem_q[idx_q] <= '0;
      end
      if (wr_en) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign pend_a   = pend_q[raddr_a];
  assign pend_b   = pend_q[raddr_b];
  assign clr_busy = busy;
  assign clr_done = (state_q == S_DONE);

endmodule
